// File: rtl/regbank_pkg.sv
//==============================================================================
// Module      : regbank_pkg
// Description : Shared constants, FSM state and owner encodings for the
//               register-bank arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package regbank_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MCU_ACC = 2'd1,
    ST_INT_ACC = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  typedef enum logic {
    OWN_MCU = 1'b0,
    OWN_INT = 1'b1
  } owner_e;

  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
    addr_onehot = NUM_REGS'(1) << a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//==============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker; search starts one past ptr_i.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter
  import regbank_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IDX_W'((int'(ptr_i) + k) % N);
      if (!valid_o && req_i[w_cand]) begin
        valid_o       = 1'b1;
        idx_o         = w_cand;
        gnt_o[w_cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regbank_arbiter.sv
//==============================================================================
// Module      : regbank_arbiter
// Description : 16 x 8 register bank shared by the MCU bus and NUM_REQ internal
//               requesters; MCU priority with alternation, round-robin inside.
//               Optional REGBANK_ARB_LOCK_EN adds lock_mask / wr_err.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regbank_arbiter
  import regbank_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                        CLK50,
  input  logic                        rst_n,
  input  logic                        mcu_req,
  input  logic                        mcu_we,
  input  logic [ADDR_W-1:0]           mcu_addr,
  input  logic [DATA_W-1:0]           mcu_wdata,
  output logic [DATA_W-1:0]           mcu_rdata,
  output logic                        mcu_done,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          done,
  output logic [DATA_W-1:0]           rdata,
  output logic [NUM_REGS*DATA_W-1:0]  reg_q,
  output logic [NUM_REGS-1:0]         reg_upd,
`ifdef REGBANK_ARB_LOCK_EN
  input  logic [NUM_REGS-1:0]         lock_mask,
  output logic [NUM_REQ-1:0]          wr_err,
`endif
  output logic                        busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q, state_d;
  owner_e               last_owner_q, cur_owner_q;
  logic [IDX_W-1:0]     rr_ptr_q, win_idx_q;
  logic [NUM_REQ-1:0]   win_gnt_q;

  logic [DATA_W-1:0]    bank_q [NUM_REGS];
  logic [DATA_W-1:0]    mcu_rdata_q, rdata_q;
  logic                 upd_pend_q;
  logic [ADDR_W-1:0]    upd_addr_q;
  logic                 mcu_done_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [NUM_REGS-1:0]  reg_upd_q;

  logic [NUM_REQ-1:0]   w_arb_gnt;
  logic [IDX_W-1:0]     w_arb_idx;
  logic                 w_arb_valid;

  logic                 w_acc;
  logic                 w_acc_we;
  logic [ADDR_W-1:0]    w_acc_addr;
  logic [DATA_W-1:0]    w_acc_wdata;
  logic                 w_locked;
  logic                 w_bank_wr;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (w_arb_gnt),
    .idx_o   (w_arb_idx),
    .valid_o (w_arb_valid)
  );

  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // MCU yields only when it owned the previous access and someone is waiting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mcu_req && ((last_owner_q != OWN_MCU) || !w_arb_valid)) state_d = ST_MCU_ACC;
        else if (w_arb_valid)                                        state_d = ST_INT_ACC;
      end
      ST_MCU_ACC, ST_INT_ACC: state_d = ST_RESP;
      ST_RESP:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    w_acc       = 1'b0;
    w_acc_we    = 1'b0;
    w_acc_addr  = '0;
    w_acc_wdata = '0;
    if (state_q == ST_MCU_ACC) begin
      w_acc       = 1'b1;
      w_acc_we    = mcu_we;
      w_acc_addr  = mcu_addr;
      w_acc_wdata = mcu_wdata;
    end else if (state_q == ST_INT_ACC) begin
      w_acc       = 1'b1;
      w_acc_we    = req_we[win_idx_q];
      w_acc_addr  = req_addr[int'(win_idx_q)*ADDR_W +: ADDR_W];
      w_acc_wdata = req_wdata[int'(win_idx_q)*DATA_W +: DATA_W];
    end
`ifdef REGBANK_ARB_LOCK_EN
    w_locked  = (state_q == ST_INT_ACC) && w_acc_we && lock_mask[w_acc_addr];
`else
    w_locked  = 1'b0;
`endif
    w_bank_wr = w_acc && w_acc_we && !w_locked;
  end

  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OWN_INT;
      cur_owner_q  <= OWN_INT;
      rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
      win_idx_q    <= '0;
      win_gnt_q    <= '0;
    end else if (state_q == ST_IDLE) begin
      if (state_d == ST_MCU_ACC) begin
        cur_owner_q <= OWN_MCU;
      end else if (state_d == ST_INT_ACC) begin
        cur_owner_q <= OWN_INT;
        win_idx_q   <= w_arb_idx;
        win_gnt_q   <= w_arb_gnt;
        rr_ptr_q    <= w_arb_idx;
      end
    end else if (state_q == ST_RESP) begin
      last_owner_q <= cur_owner_q;
    end
  end

  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
      mcu_rdata_q <= '0;
      rdata_q     <= '0;
      upd_pend_q  <= 1'b0;
      upd_addr_q  <= '0;
    end else begin
      if (w_bank_wr) bank_q[w_acc_addr] <= w_acc_wdata;
      if (w_acc) begin
        upd_pend_q <= w_bank_wr;
        upd_addr_q <= w_acc_addr;
        if (!w_acc_we) begin
          if (state_q == ST_MCU_ACC) mcu_rdata_q <= bank_q[w_acc_addr];
          else                       rdata_q     <= bank_q[w_acc_addr];
        end
      end
    end
  end

  // Completion and update strobes are registered out of RESP so they align.
  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      mcu_done_q <= 1'b0;
      done_q     <= '0;
      reg_upd_q  <= '0;
    end else begin
      mcu_done_q <= (state_q == ST_RESP) && (cur_owner_q == OWN_MCU);
      done_q     <= ((state_q == ST_RESP) && (cur_owner_q == OWN_INT)) ? win_gnt_q : '0;
      reg_upd_q  <= ((state_q == ST_RESP) && upd_pend_q) ? addr_onehot(upd_addr_q) : '0;
    end
  end

`ifdef REGBANK_ARB_LOCK_EN
  logic               err_pend_q;
  logic [NUM_REQ-1:0] wr_err_q;

  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      err_pend_q <= 1'b0;
      wr_err_q   <= '0;
    end else begin
      if (w_acc) err_pend_q <= w_locked;
      wr_err_q <= ((state_q == ST_RESP) && err_pend_q) ? win_gnt_q : '0;
    end
  end

  assign wr_err = wr_err_q;
`endif

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
      assign reg_q[g*DATA_W +: DATA_W] = bank_q[g];
    end
  endgenerate

  assign mcu_rdata = mcu_rdata_q;
  assign rdata     = rdata_q;
  assign mcu_done  = mcu_done_q;
  assign done      = done_q;
  assign reg_upd   = reg_upd_q;

endmodule

`default_nettype wire

// File: tb/tb_regbank_arbiter.sv
//==============================================================================
// Module      : tb_regbank_arbiter
// Description : Directed table-driven bench for regbank_arbiter; lock checks
//               are compiled in when REGBANK_ARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_regbank_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;

  logic                       CLK50;
  logic                       rst_n;
  logic                       mcu_req, mcu_we;
  logic [ADDR_W-1:0]          mcu_addr;
  logic [DATA_W-1:0]          mcu_wdata, mcu_rdata;
  logic                       mcu_done;
  logic [NUM_REQ-1:0]         req, req_we, done;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*DATA_W-1:0]  req_wdata;
  logic [DATA_W-1:0]          rdata;
  logic [NUM_REGS*DATA_W-1:0] reg_q;
  logic [NUM_REGS-1:0]        reg_upd;
  logic                       busy;
`ifdef REGBANK_ARB_LOCK_EN
  logic [NUM_REGS-1:0]        lock_mask;
  logic [NUM_REQ-1:0]         wr_err;
`endif

  regbank_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .CLK50     (CLK50),
    .rst_n     (rst_n),
    .mcu_req   (mcu_req),
    .mcu_we    (mcu_we),
    .mcu_addr  (mcu_addr),
    .mcu_wdata (mcu_wdata),
    .mcu_rdata (mcu_rdata),
    .mcu_done  (mcu_done),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .rdata     (rdata),
    .reg_q     (reg_q),
    .reg_upd   (reg_upd),
`ifdef REGBANK_ARB_LOCK_EN
    .lock_mask (lock_mask),
    .wr_err    (wr_err),
`endif
    .busy      (busy)
  );

  initial CLK50 = 1'b0;
  always #5 CLK50 = ~CLK50;

  typedef struct {
    bit         is_mcu;
    int         rq;
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] model [NUM_REGS];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_model();
    logic [127:0] r;
    for (int i = 0; i < NUM_REGS; i++) r[i*DATA_W +: DATA_W] = model[i];
    return r;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    int lat;
    bit seen;
    logic [NUM_REQ-1:0]  exp_done;
    logic [NUM_REGS-1:0] exp_upd;
    if (v.is_mcu) begin
      mcu_we = v.we; mcu_addr = v.addr; mcu_wdata = v.wdata; mcu_req = 1'b1;
    end else begin
      req_we[v.rq] = v.we;
      req_addr[v.rq*ADDR_W +: ADDR_W]  = v.addr;
      req_wdata[v.rq*DATA_W +: DATA_W] = v.wdata;
      req[v.rq] = 1'b1;
    end
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 10) begin
      @(negedge CLK50);
      lat++;
      if (lat == 1) check($sformatf("v%0d_busy", id), busy, 1'b1);
      if (mcu_done || (|done)) seen = 1'b1;
    end
    check($sformatf("v%0d_latency", id), seen ? lat : 99, 3);
    exp_done = v.is_mcu ? '0 : NUM_REQ'(1) << v.rq;
    check($sformatf("v%0d_done", id), {mcu_done, done}, {v.is_mcu, exp_done});
    if (v.we) begin
      model[v.addr] = v.wdata;
      exp_upd = NUM_REGS'(1) << v.addr;
    end else begin
      exp_upd = '0;
      check($sformatf("v%0d_rdata", id), v.is_mcu ? mcu_rdata : rdata, v.exp_rdata);
    end
    check($sformatf("v%0d_reg_upd", id), reg_upd, exp_upd);
    check($sformatf("v%0d_reg_q", id), reg_q, pack_model());
    mcu_req = 1'b0;
    req     = '0;
    @(negedge CLK50);
    check($sformatf("v%0d_pulse_end", id), {mcu_done, done, reg_upd}, '0);
  endtask

  vec_t vecs [11];

  initial begin
    int cyc;
    int n;
    bit any_done;

    vecs[0]  = '{1'b1, 0, 1'b1, 4'h3, 8'hA5, 8'h00};
    vecs[1]  = '{1'b1, 0, 1'b0, 4'h3, 8'h00, 8'hA5};
    vecs[2]  = '{1'b0, 3, 1'b1, 4'hF, 8'h3C, 8'h00};
    vecs[3]  = '{1'b0, 0, 1'b0, 4'hF, 8'h00, 8'h3C};
    vecs[4]  = '{1'b0, 2, 1'b1, 4'h7, 8'h11, 8'h00};
    vecs[5]  = '{1'b1, 0, 1'b0, 4'h7, 8'h00, 8'h11};
    vecs[6]  = '{1'b0, 1, 1'b0, 4'h3, 8'h00, 8'hA5};
    vecs[7]  = '{1'b1, 0, 1'b1, 4'h0, 8'hFF, 8'h00};
    vecs[8]  = '{1'b0, 0, 1'b0, 4'h0, 8'h00, 8'hFF};
    vecs[9]  = '{1'b0, 1, 1'b1, 4'h3, 8'h5A, 8'h00};
    vecs[10] = '{1'b1, 0, 1'b0, 4'h3, 8'h00, 8'h5A};

    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    rst_n = 1'b0; mcu_req = 1'b0; mcu_we = 1'b0; mcu_addr = '0; mcu_wdata = '0;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
`ifdef REGBANK_ARB_LOCK_EN
    lock_mask = '0;
`endif

    repeat (3) @(negedge CLK50);
    check("rst_reg_q", reg_q, '0);
    check("rst_strobes", {mcu_done, done, reg_upd, busy}, '0);
    check("rst_rdata", {mcu_rdata, rdata}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge CLK50);
    check("idle_after_rst", {busy, mcu_done, done}, '0);

    // Three simultaneous readers: pointer starts at NUM_REQ-1, so order is 0,1,2.
    req_we = '0;
    req_addr = {4'd0, 4'd2, 4'd1, 4'd0};
    req = 4'b0111;
    cyc = 0; n = 0;
    while (n < 3 && cyc < 15) begin
      @(negedge CLK50);
      cyc++;
      if (|done) begin
        check($sformatf("rr_order%0d", n), done, NUM_REQ'(1) << n);
        check($sformatf("rr_cycle%0d", n), cyc, 3*(n+1));
        check($sformatf("rr_rdata%0d", n), rdata, '0);
        req = req & ~done;
        n++;
      end
    end
    check("rr_count", n, 3);
    req = '0;

    // MCU and requester 1 held together: service must alternate.
    mcu_we = 1'b0; mcu_addr = 4'h0; mcu_req = 1'b1;
    req = 4'b0010;
    cyc = 0; n = 0;
    while (n < 4 && cyc < 16) begin
      @(negedge CLK50);
      cyc++;
      if (mcu_done || (|done)) begin
        check($sformatf("alt_grant%0d", n), {mcu_done, done},
              (n % 2 == 0) ? 5'b10000 : 5'b00010);
        check($sformatf("alt_cycle%0d", n), cyc, 3*(n+1));
        n++;
        if (n == 4) begin
          mcu_req = 1'b0;
          req = '0;
        end
      end
    end
    check("alt_count", n, 4);
    mcu_req = 1'b0;
    req = '0;
    @(negedge CLK50);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Reset asserted while an internal write sits in INT_ACC.
    req_we[1] = 1'b1;
    req_addr[1*ADDR_W +: ADDR_W]  = 4'h9;
    req_wdata[1*DATA_W +: DATA_W] = 8'h99;
    req[1] = 1'b1;
    @(posedge CLK50);
    #1;
    check("abort_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge CLK50);
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    check("abort_bank", reg_q, '0);
    check("abort_state", {busy, mcu_done, done, reg_upd}, '0);
    req = '0;
    @(negedge CLK50);
    rst_n = 1'b1;
    any_done = 1'b0;
    repeat (5) begin
      @(negedge CLK50);
      if (mcu_done || (|done) || busy) any_done = 1'b1;
    end
    check("abort_no_done", any_done, 1'b0);

`ifdef REGBANK_ARB_LOCK_EN
    lock_mask = 16'h0020;
    req_we[2] = 1'b1;
    req_addr[2*ADDR_W +: ADDR_W]  = 4'h5;
    req_wdata[2*DATA_W +: DATA_W] = 8'h77;
    req[2] = 1'b1;
    cyc = 0; any_done = 1'b0;
    while (!any_done && cyc < 10) begin
      @(negedge CLK50);
      cyc++;
      if (|done) any_done = 1'b1;
    end
    check("lock_latency", any_done ? cyc : 99, 3);
    check("lock_done", done, 4'b0100);
    check("lock_wr_err", wr_err, 4'b0100);
    check("lock_reg_q", reg_q, pack_model());
    check("lock_reg_upd", reg_upd, '0);
    req = '0;
    @(negedge CLK50);
    check("lock_err_end", wr_err, '0);
    begin
      vec_t lv;
      lv = '{1'b1, 0, 1'b1, 4'h5, 8'h77, 8'h00};
      run_vec(100, lv);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regbank_arbiter.md
# regbank_arbiter

Shared-register-bank controller between the MCU parallel bus and on-chip FPGA logic. Owns the 16 x 8-bit register bank, serialises accesses from the MCU bus port and NUM_REQ internal requesters, and emits per-register update strobes to the consuming logic. The MCU port has priority, with alternation so internal requesters are never starved; internal requesters are served round-robin.

## Interface
- NUM_REQ, 4, internal requester count (1..8)
- NUM_REGS, 16, register count (power of 2)
- ADDR_W, 4, log2(NUM_REGS)
- DATA_W, 8, register width
- CLK50  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- mcu_req  in  1  MCU access request, level, held until mcu_done
- mcu_we  in  1  1 = write, 0 = read; stable while mcu_req
- mcu_addr  in  ADDR_W  register index
- mcu_wdata  in  DATA_W  write data
- mcu_rdata  out  DATA_W  read data, valid with mcu_done
- mcu_done  out  1  one-cycle completion pulse
- req  in  NUM_REQ  internal request, level, held until done[i]
- req_we  in  NUM_REQ  per-requester write flag
- req_addr  in  NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed likewise
- done  out  NUM_REQ  one-hot completion pulse
- rdata  out  DATA_W  shared read data, valid with any done bit
- reg_q  out  NUM_REGS*DATA_W  current bank contents, packed
- reg_upd  out  NUM_REGS  one-cycle strobe on the cycle after a register is written
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, MCU_ACC, INT_ACC, RESP.
- IDLE: if mcu_req and (last_owner != MCU or no req bit set) -> MCU_ACC; else if any req bit set -> INT_ACC, latching winner; else stay.
- Round-robin: search starts at rr_ptr+1 modulo NUM_REQ; after a grant, rr_ptr <= winner index.
- MCU_ACC / INT_ACC: single cycle; write: bank[addr] <= wdata, reg_upd[addr] set for the following cycle; read: rdata register <= bank[addr]. -> RESP.
- RESP: pulse mcu_done or done[winner]; update last_owner; -> IDLE.
- Requester must drop its request on the cycle of its done pulse; a request still high in IDLE after done is treated as a new access.
- Reads return the pre-write value if the same register was written in the immediately preceding access? No: accesses are serialised, so reads always see all completed writes.
- Address out of range is impossible by width; no error path.
- Reset: bank all 0, reg_q 0, reg_upd 0, mcu_rdata/rdata 0, mcu_done/done 0, busy 0, rr_ptr NUM_REQ-1 (first search starts at 0), last_owner = INT, state IDLE.
- Reset asserted mid-access: access aborted, no done pulse, bank cleared.

## Timing
- Request sampled in IDLE at edge N; access at N+1; done pulse and rdata valid cycle N+2 -> N+3 (3-cycle turnaround, back-to-back throughput one access per 3 cycles).
- reg_upd[a] high exactly one cycle, aligned with the done pulse; reg_q reflects the new value in the same cycle.
- Simultaneous mcu_req and req: MCU wins unless MCU owned the previous access.

## Configuration
- REGBANK_ARB_LOCK_EN defined: adds input lock_mask [NUM_REGS] and output wr_err [NUM_REQ]; internal-requester writes to registers with lock_mask bit set are dropped (bank and reg_upd unchanged), done still pulses, wr_err[i] pulses with it. MCU writes ignore the lock.
- Not defined: ports absent, all writes take effect.

## Structure
- Package regbank_pkg: NUM_REGS, ADDR_W, DATA_W constants, FSM state enum, owner enum (MCU/INT).
- Sub-module rr_arbiter (NUM_REQ request vector + pointer -> one-hot grant and index), purely combinational.

## Test plan
- Reset, MCU write 0xA5 to reg 3 -> mcu_done at cycle 3, reg_q[3]=0xA5, reg_upd[3] one pulse; MCU read reg 3 -> mcu_rdata 0xA5.
- Requesters 0,1,2 simultaneously read -> done order 0,1,2, each 3 cycles apart.
- mcu_req and req[1] both held continuously -> grants alternate MCU, 1, MCU, 1.
- req[3] write 0x3C to reg 15 then req[0] read reg 15 -> rdata 0x3C; rr wrap from 3 to 0 verified.
- rst_n low during INT_ACC -> no done, bank all 0, state IDLE.
- With REGBANK_ARB_LOCK_EN, lock_mask[5]=1, req[2] write 0x77 to reg 5 -> done[2] and wr_err[2] pulse, reg_q[5] unchanged; MCU write to reg 5 succeeds.
